// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-aligned word updates.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic                    din_valid,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [6:0]              dout,
  output logic                    dout_dp,
  output logic [NUM_DIGITS-1:0]   dout_ann,
  output logic                    upd_pending,
  output logic                    frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_din;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_pend_blank;
  logic                    r_upd_pending;
  logic [4*NUM_DIGITS-1:0] r_disp_din;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [NUM_DIGITS-1:0]   r_disp_blank;
  logic [6:0]              r_dout;
  logic                    r_dout_dp;
  logic [NUM_DIGITS-1:0]   r_dout_ann;
  logic                    r_frame_done;

  logic                    w_tick;
  logic                    w_wrap;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] w_pend_din_nxt;
  logic [NUM_DIGITS-1:0]   w_pend_dp_nxt;
  logic [NUM_DIGITS-1:0]   w_pend_blank_nxt;
  logic                    w_upd_nxt;
  logic [4*NUM_DIGITS-1:0] w_disp_din_nxt;
  logic [NUM_DIGITS-1:0]   w_disp_dp_nxt;
  logic [NUM_DIGITS-1:0]   w_disp_blank_nxt;
  logic [NUM_DIGITS-1:0]   w_lzb;
  logic [3:0]              w_nib;
  logic                    w_dp_sel;
  logic                    w_blank_sel;
  logic [NUM_DIGITS-1:0]   w_ann_nxt;
  logic [6:0]              w_dout_nxt;
  logic                    w_dout_dp_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  assign w_tick    = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_wrap    = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_cnt_nxt = w_tick ? '0 : r_cnt + CNT_W'(1);
  assign w_idx_nxt = w_wrap ? '0 : (w_tick ? r_idx + IDX_W'(1) : r_idx);

  // A strobe landing on the wrap cycle bypasses pending and goes straight to display.
  always_comb begin
    w_pend_din_nxt   = r_pend_din;
    w_pend_dp_nxt    = r_pend_dp;
    w_pend_blank_nxt = r_pend_blank;
    w_upd_nxt        = r_upd_pending;
    w_disp_din_nxt   = r_disp_din;
    w_disp_dp_nxt    = r_disp_dp;
    w_disp_blank_nxt = r_disp_blank;
    if (din_valid) begin
      w_pend_din_nxt   = din;
      w_pend_dp_nxt    = dp_in;
      w_pend_blank_nxt = blank_in;
    end
    if (w_wrap) begin
      w_upd_nxt = 1'b0;
      if (din_valid) begin
        w_disp_din_nxt   = din;
        w_disp_dp_nxt    = dp_in;
        w_disp_blank_nxt = blank_in;
      end else if (r_upd_pending) begin
        w_disp_din_nxt   = r_pend_din;
        w_disp_dp_nxt    = r_pend_dp;
        w_disp_blank_nxt = r_pend_blank;
      end
    end else if (din_valid) begin
      w_upd_nxt = 1'b1;
    end
  end

`ifdef SEG7_LZB_EN
  logic w_zero_run;

  // Zero run from the top digit stops at the first nonzero nibble or lit dp.
  always_comb begin
    w_lzb      = '0;
    w_zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (w_zero_run && (w_disp_din_nxt[4*k +: 4] == 4'h0) && !w_disp_dp_nxt[k])
        w_lzb[k] = 1'b1;
      else
        w_zero_run = 1'b0;
    end
  end
`else
  assign w_lzb = '0;
`endif

  // Outputs are registered from next-state values so they track idx without lag.
  always_comb begin
    w_nib       = 4'h0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b0;
    w_ann_nxt   = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_idx_nxt == IDX_W'(k)) begin
        w_nib        = w_disp_din_nxt[4*k +: 4];
        w_dp_sel     = w_disp_dp_nxt[k];
        w_blank_sel  = w_disp_blank_nxt[k] | w_lzb[k];
        w_ann_nxt[k] = 1'b0;
      end
    end
  end

  assign w_dout_nxt    = w_blank_sel ? 7'b1111111 : seg_decode(w_nib);
  assign w_dout_dp_nxt = w_blank_sel | ~w_dp_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_pend_din    <= '0;
      r_pend_dp     <= '0;
      r_pend_blank  <= '0;
      r_upd_pending <= 1'b0;
      r_disp_din    <= '0;
      r_disp_dp     <= '0;
      r_disp_blank  <= '0;
      r_dout        <= 7'b1111111;
      r_dout_dp     <= 1'b1;
      r_dout_ann    <= '1;
      r_frame_done  <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_idx         <= w_idx_nxt;
      r_pend_din    <= w_pend_din_nxt;
      r_pend_dp     <= w_pend_dp_nxt;
      r_pend_blank  <= w_pend_blank_nxt;
      r_upd_pending <= w_upd_nxt;
      r_disp_din    <= w_disp_din_nxt;
      r_disp_dp     <= w_disp_dp_nxt;
      r_disp_blank  <= w_disp_blank_nxt;
      r_dout        <= w_dout_nxt;
      r_dout_dp     <= w_dout_dp_nxt;
      r_dout_ann    <= w_ann_nxt;
      r_frame_done  <= w_wrap;
    end
  end

  assign dout        = r_dout;
  assign dout_dp     = r_dout_dp;
  assign dout_ann    = r_dout_ann;
  assign upd_pending = r_upd_pending;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed and random steps checked against a
// model driven by edge count since reset release (honours SEG7_LZB_EN).
module tb_seg7_scan_driver;
  localparam int N = 4;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [4*N-1:0] din;
  logic         din_valid;
  logic [N-1:0] dp_in;
  logic [N-1:0] blank_in;
  logic [6:0]   dout;
  logic         dout_dp;
  logic [N-1:0] dout_ann;
  logic         upd_pending;
  logic         frame_done;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .dp_in(dp_in), .blank_in(blank_in), .dout(dout), .dout_dp(dout_dp),
    .dout_ann(dout_ann), .upd_pending(upd_pending), .frame_done(frame_done)
  );

  logic [6:0]   seg_tab [16];
  int           e;
  bit           m_rst;
  logic [15:0]  m_disp_d, m_pend_d;
  logic [3:0]   m_disp_dp, m_pend_dp, m_disp_bl, m_pend_bl;
  bit           m_upd;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic check(input string tag, input string name,
                       input logic [15:0] obs, input logic [15:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s/%s: observed %h, required %h", tag, name, obs, exp_v);
    end
  endtask

  // Frame boundaries are every R*N edges after reset release.
  task automatic model_edge(input bit rst_v, input bit vld, input logic [15:0] d,
                            input logic [3:0] dp, input logic [3:0] bl);
    if (rst_v) begin
      m_rst = 1; e = 0; m_upd = 0;
      m_disp_d = '0; m_pend_d = '0; m_disp_dp = '0;
      m_pend_dp = '0; m_disp_bl = '0; m_pend_bl = '0;
    end else begin
      m_rst = 0;
      e++;
      if (e % (R*N) == 0) begin
        if (vld) begin
          m_disp_d = d; m_disp_dp = dp; m_disp_bl = bl;
          m_pend_d = d; m_pend_dp = dp; m_pend_bl = bl;
        end else if (m_upd) begin
          m_disp_d = m_pend_d; m_disp_dp = m_pend_dp; m_disp_bl = m_pend_bl;
        end
        m_upd = 0;
      end else if (vld) begin
        m_pend_d = d; m_pend_dp = dp; m_pend_bl = bl; m_upd = 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    int idx;
    logic [3:0] nib;
    logic [N-1:0] lzb;
    logic [N-1:0] exp_ann;
    logic [6:0] exp_dout;
    bit exp_dp, exp_fd, blank;
    if (m_rst) begin
      exp_dout = 7'b1111111; exp_dp = 1; exp_ann = '1; exp_fd = 0;
    end else begin
      idx = (e / R) % N;
      nib = m_disp_d[idx*4 +: 4];
      lzb = '0;
`ifdef SEG7_LZB_EN
      begin
        bit run;
        run = 1;
        for (int k = N - 1; k >= 1; k--) begin
          if (run && m_disp_d[k*4 +: 4] == 4'h0 && !m_disp_dp[k]) lzb[k] = 1'b1;
          else run = 0;
        end
      end
`endif
      blank    = m_disp_bl[idx] | lzb[idx];
      exp_dout = blank ? 7'b1111111 : seg_tab[nib];
      exp_dp   = blank ? 1'b1 : ~m_disp_dp[idx];
      exp_ann  = '1;
      exp_ann[idx] = 1'b0;
      exp_fd   = (e > 0) && (e % (R*N) == 0);
    end
    check(tag, "dout",        16'(dout),        16'(exp_dout));
    check(tag, "dout_dp",     16'(dout_dp),     16'(exp_dp));
    check(tag, "dout_ann",    16'(dout_ann),    16'(exp_ann));
    check(tag, "frame_done",  16'(frame_done),  16'(exp_fd));
    check(tag, "upd_pending", 16'(upd_pending), 16'(m_upd));
  endtask

  task automatic step(input bit rst_v, input bit vld, input logic [15:0] d,
                      input logic [3:0] dp, input logic [3:0] bl, input string tag);
    @(negedge clk);
    reset = rst_v; din_valid = vld; din = d; dp_in = dp; blank_in = bl;
    @(posedge clk);
    model_edge(rst_v, vld, d, dp, bl);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++)
      step(0, 0, 16'($urandom), 4'($urandom), 4'($urandom), tag);
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    reset = 1; din_valid = 0; din = '0; dp_in = '0; blank_in = '0;
    e = 0; m_rst = 1; m_upd = 0;

    for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 4'h0, 4'h0, "reset");
    idle(40, "scan");

    step(0, 1, 16'h12AF, 4'h0, 4'h0, "capture");
    idle(40, "commit");

    while ((e + 1) % (R*N) != 0) idle(1, "prewrap");
    step(0, 1, 16'h0008, 4'h0, 4'h0, "wrapcap");
    idle(20, "wrapshow");

    step(0, 1, 16'h1111, 4'h0, 4'b0001, "blank");
    idle(36, "blankshow");

    step(0, 1, 16'h0040, 4'h0, 4'h0, "lzb");
    idle(36, "lzbshow");
    step(0, 1, 16'h0040, 4'b0100, 4'h0, "lzbdp");
    idle(36, "lzbdpshow");

    while (e % (R*N) != 5) idle(1, "prerst");
    step(0, 1, 16'hBEEF, 4'hF, 4'h0, "rstpend");
    idle(1, "rstpend2");
    step(1, 0, 16'h0, 4'h0, 4'h0, "rstmid");
    idle(40, "afterrst");

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) == 0),
           16'($urandom), 4'($urandom), 4'($urandom), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
